rat_flush_ctrl: RTL and testbench
=================================

Name: rat_flush_ctrl

Overview:
- Sequences recovery of the register alias table after a ROB flush (mispredict or exception).
- Sits between decode/ROB and the RAT and owns the RAT's write ports.
- In normal operation, forwards rename writes and commit clears unchanged.
- On a flush, drops all new traffic, stalls decode, and walks the RAT to force every entry valid, a few entries per cycle. It then signals completion.

Parameters:
- REG_NUM, 32, architectural registers / RAT entries.
- ROB_PTR_W, 4, ROB id width.
- CLR_LANES, 4, RAT entries force-valid per walk cycle; power of 2 dividing REG_NUM.
- WALK_W, $clog2(REG_NUM/CLR_LANES), walk counter width; minimum 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_req  in  1  single-cycle flush pulse from ROB
- flush_done  out  1  single-cycle pulse: RAT fully recovered
- dec_stall  out  1  decode must hold its instruction
- dec_rd_wr  in  1  rename request
- dec_rd_addr  in  5  rename destination
- dec_rob_id  in  ROB_PTR_W  allocated ROB id
- cmt_valid  in  1  ROB commit
- cmt_rd_addr  in  5  committed destination
- cmt_rob_id  in  ROB_PTR_W  committed ROB id
- rat_rd_wr  out  1  rename write to RAT
- rat_rd_addr  out  5  rename destination to RAT
- rat_rob_id  out  ROB_PTR_W  rename ROB id to RAT
- rat_commit  out  1  commit to RAT
- rat_cm_rd_addr  out  5  commit destination to RAT
- rat_cm_rob_id  out  ROB_PTR_W  commit ROB id to RAT
- rat_clr_en  out  1  force entries valid
- rat_clr_base  out  5  first entry of a CLR_LANES-aligned group to clear

Behaviour:
- Clock and reset: single clock domain; rst_n asynchronous, active low, synchronously deasserted externally.
- Reset state: IDLE, walk_cnt=0, all registered outputs 0. Control outputs (dec_stall, flush_done, rat_clr_en) are all 0 in reset.
- States: IDLE, WALK, DONE.
- IDLE:
  - rat_rd_wr = dec_rd_wr & ~flush_req.
  - rat_commit = cmt_valid & ~flush_req.
  - Address/id fields are passed combinationally.
  - dec_stall = flush_req.
  - On flush_req: walk_cnt<=0, go to WALK.
- WALK:
  - rat_clr_en=1, rat_clr_base = walk_cnt*CLR_LANES.
  - rat_rd_wr=0, rat_commit=0, dec_stall=1.
  - walk_cnt increments each cycle.
  - When walk_cnt == REG_NUM/CLR_LANES-1, go to DONE.
- DONE: flush_done=1 and dec_stall=1 for one cycle, then IDLE.
- Latency, defaults (8 walk cycles), flush_req at cycle T:
  - WALK during T+1..T+8;
  - DONE at T+9;
  - dec_stall=0 and forwarding resume at T+10.
- flush_req during WALK: restart. walk_cnt<=0 next cycle and stay in WALK; the pulse is not lost.
- flush_req during DONE: no flush_done pulse; go to WALK with walk_cnt=0.
- Same-cycle flush_req and rename or commit: the rename/commit is dropped, because the flush kills it.
- Same-cycle rename and commit in IDLE: both forwarded. The RAT resolves this with rename priority.
- x0: the walk includes entry 0 (harmless); no special handling.
- Wrap: walk_cnt never exceeds REG_NUM/CLR_LANES-1.
- rst_n asserted mid-walk: immediately IDLE, all outputs 0, no flush_done.
- Output stability:
  - rat_clr_en and rat_clr_base are combinational from state and walk_cnt only, and are glitch-free relative to clk.
  - dec_stall depends combinationally on flush_req.

Optional Feature:
- Macro: RAT_FLUSH_PERF_EN.
- Defined: adds outputs perf_flush_cnt (32) and perf_stall_cycles (32), both reset 0 by rst_n.
  - perf_flush_cnt increments once per flush_done pulse.
  - perf_stall_cycles increments every cycle dec_stall=1.
  - Both saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared core package:
  - typedef enum rat_flush_state_t {IDLE, WALK, DONE};
  - localparam ARCH_REG_NUM=32;
  - localparam ARCH_REG_W=5.
- Sub-module: rat_walk_cnt, a modulo counter with clear, increment and last flag, parameterised by terminal count. It is reused by future checkpoint walkers.

Test Plan:
- Reset then idle traffic: dec_rd_wr=1, addr=5, id=3 -> rat_rd_wr=1, rat_rd_addr=5, rat_rob_id=3 in the same cycle; dec_stall=0.
- Single flush at T (defaults):
  - rat_clr_en=1 with rat_clr_base 0,4,...,28 on T+1..T+8;
  - flush_done at T+9;
  - dec_stall high T..T+9, low T+10.
- flush_req with cmt_valid=1 (addr=7) and dec_rd_wr=1 in the same cycle -> rat_commit=0, rat_rd_wr=0.
- Second flush_req at T+4 -> rat_clr_base restarts at 0 on T+5; flush_done only at T+13; exactly one flush_done pulse.
- rst_n low at T+3 mid-walk -> rat_clr_en=0 and dec_stall=0 immediately (asynchronous), no flush_done; normal forwarding after release.
- RAT_FLUSH_PERF_EN defined, two back-to-back complete flushes -> perf_flush_cnt=2, perf_stall_cycles=20.

Source files
------------

// File: rtl/rat_flush_ctrl_pkg.sv
// rat_flush_ctrl_pkg
//   Shared definitions for the RAT flush/recovery controller and the walk
//   counters that future checkpoint walkers will reuse.
//   - rat_flush_state_t : recovery FSM states (IDLE, WALK, DONE)
//   - ARCH_REG_NUM      : number of architectural registers
//   - ARCH_REG_W        : width of an architectural register index
//   - walk_width()      : counter width for a given number of walk groups
package rat_flush_ctrl_pkg;

  localparam int ARCH_REG_NUM = 32;
  localparam int ARCH_REG_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } rat_flush_state_t;

  // A walk of a single group still needs a 1-bit counter.
  function automatic int walk_width(input int groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

endpackage

// File: rtl/rat_flush_ctrl_walk_cnt.sv
// rat_walk_cnt
//   Modulo counter with synchronous clear, increment and a terminal-count
//   flag. Counts 0..TERM and wraps back to 0 on an increment at TERM.
//   Clear has priority over increment.
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset (counter -> 0)
//   clr_i   in  force the counter to 0 next cycle
//   inc_i   in  advance the counter by one (modulo TERM+1)
//   cnt_o   out current count
//   last_o  out count equals TERM
module rat_walk_cnt #(
  parameter int TERM = 7,
  parameter int W    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == TERM_V) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == TERM_V);

endmodule

// File: rtl/rat_flush_ctrl.sv
// rat_flush_ctrl
//   Owns the RAT write ports. In normal operation rename writes and commit
//   clears from decode/ROB are forwarded unchanged. On a ROB flush all new
//   traffic is dropped, decode is stalled, and the RAT is walked CLR_LANES
//   entries per cycle forcing every entry valid; a one-cycle flush_done
//   pulse then marks the RAT as recovered.
// Optional build macro: RAT_FLUSH_PERF_EN adds saturating 32-bit counters
//   perf_flush_cnt (flush_done pulses) and perf_stall_cycles (cycles with
//   dec_stall high).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   flush_req                       single-cycle flush pulse from ROB
//   flush_done                      single-cycle pulse, RAT recovered
//   dec_stall                       decode must hold its instruction
//   dec_rd_wr/addr/rob_id           rename request from decode
//   cmt_valid/rd_addr/rob_id        commit from ROB
//   rat_rd_wr/rd_addr/rob_id        rename write to RAT
//   rat_commit/cm_rd_addr/cm_rob_id commit to RAT
//   rat_clr_en, rat_clr_base        force-valid of one aligned entry group
//   perf_flush_cnt, perf_stall_cycles (RAT_FLUSH_PERF_EN only)
//   dbg_state                       current FSM state for observation
//
// Handshake: every request input is a single-cycle qualifier (no ready);
// the matching RAT output is asserted in the same cycle when forwarded, and
// the request is simply dropped when not forwarded (flush or walk).
module rat_flush_ctrl
  import rat_flush_ctrl_pkg::*;
#(
  parameter int REG_NUM   = ARCH_REG_NUM,
  parameter int ROB_PTR_W = 4,
  parameter int CLR_LANES = 4,
  parameter int WALK_W    = walk_width(REG_NUM / CLR_LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  dec_stall,
  input  logic                  dec_rd_wr,
  input  logic [ARCH_REG_W-1:0] dec_rd_addr,
  input  logic [ROB_PTR_W-1:0]  dec_rob_id,
  input  logic                  cmt_valid,
  input  logic [ARCH_REG_W-1:0] cmt_rd_addr,
  input  logic [ROB_PTR_W-1:0]  cmt_rob_id,
  output logic                  rat_rd_wr,
  output logic [ARCH_REG_W-1:0] rat_rd_addr,
  output logic [ROB_PTR_W-1:0]  rat_rob_id,
  output logic                  rat_commit,
  output logic [ARCH_REG_W-1:0] rat_cm_rd_addr,
  output logic [ROB_PTR_W-1:0]  rat_cm_rob_id,
  output logic                  rat_clr_en,
  output logic [ARCH_REG_W-1:0] rat_clr_base,
`ifdef RAT_FLUSH_PERF_EN
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_stall_cycles,
`endif
  output logic [1:0]            dbg_state
);

  localparam int WALK_GROUPS = REG_NUM / CLR_LANES;
  localparam int LANE_SH     = $clog2(CLR_LANES);

  rat_flush_state_t  state_q;
  logic              clr_en_q;
  logic              done_q;
  logic [WALK_W-1:0] walk_cnt;
  logic              walk_last;
  logic              fwd_en;

  // Every flush restarts the walk from group 0, whatever the state.
  rat_walk_cnt #(
    .TERM (WALK_GROUPS - 1),
    .W    (WALK_W)
  ) u_walk_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush_req),
    .inc_i  (state_q == WALK),
    .cnt_o  (walk_cnt),
    .last_o (walk_last)
  );

  // Recovery FSM. clr_en_q/done_q are registered copies of "next state is
  // WALK/DONE" so the RAT sees clean, glitch-free controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      clr_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q  <= WALK;
            clr_en_q <= 1'b1;
            done_q   <= 1'b0;
          end else begin
            state_q  <= IDLE;
            clr_en_q <= 1'b0;
            done_q   <= 1'b0;
          end
        end
        WALK: begin
          if (flush_req) begin
            state_q  <= WALK;
            clr_en_q <= 1'b1;
            done_q   <= 1'b0;
          end else if (walk_last) begin
            state_q  <= DONE;
            clr_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            state_q  <= WALK;
            clr_en_q <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        DONE: begin
          if (flush_req) begin
            state_q  <= WALK;
            clr_en_q <= 1'b1;
            done_q   <= 1'b0;
          end else begin
            state_q  <= IDLE;
            clr_en_q <= 1'b0;
            done_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          clr_en_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // A flush kills any rename/commit presented in the same cycle.
  assign fwd_en = (state_q == IDLE) & ~flush_req;

  assign rat_rd_wr      = fwd_en & dec_rd_wr;
  assign rat_rd_addr    = dec_rd_addr;
  assign rat_rob_id     = dec_rob_id;
  assign rat_commit     = fwd_en & cmt_valid;
  assign rat_cm_rd_addr = cmt_rd_addr;
  assign rat_cm_rob_id  = cmt_rob_id;

  assign dec_stall = flush_req | (state_q != IDLE);

  // A new flush arriving in DONE means the RAT is about to be walked again,
  // so recovery is not reported.
  assign flush_done = done_q & ~flush_req;

  assign rat_clr_en   = clr_en_q;
  assign rat_clr_base = ARCH_REG_W'(walk_cnt) << LANE_SH;

  assign dbg_state = state_q;

`ifdef RAT_FLUSH_PERF_EN
  logic [31:0] perf_flush_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (flush_done && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
      if (dec_stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_flush_cnt    = perf_flush_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_rat_flush_ctrl.sv
module tb_rat_flush_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       flush_req;
  logic       flush_done;
  logic       dec_stall;
  logic       dec_rd_wr;
  logic [4:0] dec_rd_addr;
  logic [3:0] dec_rob_id;
  logic       cmt_valid;
  logic [4:0] cmt_rd_addr;
  logic [3:0] cmt_rob_id;
  logic       rat_rd_wr;
  logic [4:0] rat_rd_addr;
  logic [3:0] rat_rob_id;
  logic       rat_commit;
  logic [4:0] rat_cm_rd_addr;
  logic [3:0] rat_cm_rob_id;
  logic       rat_clr_en;
  logic [4:0] rat_clr_base;
  logic [1:0] dbg_state;
`ifdef RAT_FLUSH_PERF_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cycles;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rat_flush_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .dec_stall      (dec_stall),
    .dec_rd_wr      (dec_rd_wr),
    .dec_rd_addr    (dec_rd_addr),
    .dec_rob_id     (dec_rob_id),
    .cmt_valid      (cmt_valid),
    .cmt_rd_addr    (cmt_rd_addr),
    .cmt_rob_id     (cmt_rob_id),
    .rat_rd_wr      (rat_rd_wr),
    .rat_rd_addr    (rat_rd_addr),
    .rat_rob_id     (rat_rob_id),
    .rat_commit     (rat_commit),
    .rat_cm_rd_addr (rat_cm_rd_addr),
    .rat_cm_rob_id  (rat_cm_rob_id),
    .rat_clr_en     (rat_clr_en),
    .rat_clr_base   (rat_clr_base),
`ifdef RAT_FLUSH_PERF_EN
    .perf_flush_cnt    (perf_flush_cnt),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: k = cycles since the most recent flush_req was sampled.
  // k in 1..8 -> walking group k-1; k == 9 -> recovered; otherwise idle.
  localparam int BIG = 1000;
  int k = BIG;
  logic [31:0] m_pf = 0;
  logic [31:0] m_ps = 0;
  logic [31:0] exp_q[$];

  // values captured at the last check point, for literal expectations
  logic       s_rd, s_cm, s_stall, s_clr, s_done;
  logic [4:0] s_base, s_rd_addr;
  logic [3:0] s_rob_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic step(input logic f, input logic wr, input logic [4:0] a,
                      input logic [3:0] id, input logic cv,
                      input logic [4:0] ca, input logic [3:0] cid);
    logic m_idle, m_walk, e_stall, e_rd, e_cm, e_done;
    @(negedge clk);
    flush_req   = f;
    dec_rd_wr   = wr;
    dec_rd_addr = a;
    dec_rob_id  = id;
    cmt_valid   = cv;
    cmt_rd_addr = ca;
    cmt_rob_id  = cid;
    #2;
    m_idle  = (k >= 10);
    m_walk  = (k >= 1) && (k <= 8);
    e_stall = f | ~m_idle;
    e_rd    = m_idle & wr & ~f;
    e_cm    = m_idle & cv & ~f;
    e_done  = (k == 9) & ~f;
    chk("dec_stall", 32'(dec_stall), 32'(e_stall));
    chk("rat_rd_wr", 32'(rat_rd_wr), 32'(e_rd));
    chk("rat_commit", 32'(rat_commit), 32'(e_cm));
    chk("rat_clr_en", 32'(rat_clr_en), 32'(m_walk));
    chk("flush_done", 32'(flush_done), 32'(e_done));
    if (e_rd) begin
      chk("rat_rd_addr", 32'(rat_rd_addr), 32'(a));
      chk("rat_rob_id", 32'(rat_rob_id), 32'(id));
    end
    if (e_cm) begin
      chk("rat_cm_rd_addr", 32'(rat_cm_rd_addr), 32'(ca));
      chk("rat_cm_rob_id", 32'(rat_cm_rob_id), 32'(cid));
    end
    if (m_walk) chk("rat_clr_base", 32'(rat_clr_base), 32'((k - 1) * 4));
    if (e_done) exp_q.push_back(cyc);
    if (flush_done === 1'b1) begin
      if (exp_q.size() == 0) chk("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else chk("done_cycle", 32'(cyc), exp_q.pop_front());
    end
`ifdef RAT_FLUSH_PERF_EN
    chk("perf_flush_cnt", perf_flush_cnt, m_pf);
    chk("perf_stall_cycles", perf_stall_cycles, m_ps);
`endif
    s_rd = rat_rd_wr; s_cm = rat_commit; s_stall = dec_stall;
    s_clr = rat_clr_en; s_done = flush_done; s_base = rat_clr_base;
    s_rd_addr = rat_rd_addr; s_rob_id = rat_rob_id;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      k = BIG; m_pf = 0; m_ps = 0;
    end else begin
      if (e_done && m_pf != 32'hFFFF_FFFF) m_pf++;
      if (e_stall && m_ps != 32'hFFFF_FFFF) m_ps++;
      if (f) k = 1;
      else if (k < BIG) k++;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] base_tab[8] = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28};
  int pulses;

  initial begin
    rst_n = 1'b0;
    flush_req = 0; dec_rd_wr = 0; dec_rd_addr = 0; dec_rob_id = 0;
    cmt_valid = 0; cmt_rd_addr = 0; cmt_rob_id = 0;

    // reset state
    idle_step();
    chk("rst_stall", 32'(s_stall), 32'd0);
    chk("rst_clr_en", 32'(s_clr), 32'd0);
    chk("rst_done", 32'(s_done), 32'd0);
    idle_step();
    @(negedge clk); rst_n = 1'b1;

    // idle forwarding
    step(1'b0, 1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 4'd0);
    chk("lit_fwd_wr", 32'(s_rd), 32'd1);
    chk("lit_fwd_addr", 32'(s_rd_addr), 32'd5);
    chk("lit_fwd_id", 32'(s_rob_id), 32'd3);
    chk("lit_fwd_stall", 32'(s_stall), 32'd0);
    step(1'b0, 1'b1, 5'd9, 4'd2, 1'b1, 5'd9, 4'd4);
    chk("lit_both_rd", 32'(s_rd), 32'd1);
    chk("lit_both_cm", 32'(s_cm), 32'd1);

    // single flush with same-cycle rename and commit
    step(1'b1, 1'b1, 5'd5, 4'd3, 1'b1, 5'd7, 4'd6);
    chk("lit_kill_cm", 32'(s_cm), 32'd0);
    chk("lit_kill_rd", 32'(s_rd), 32'd0);
    chk("lit_flush_stall", 32'(s_stall), 32'd1);
    for (int i = 0; i < 8; i++) begin
      idle_step();
      chk("lit_walk_en", 32'(s_clr), 32'd1);
      chk("lit_walk_base", 32'(s_base), 32'(base_tab[i]));
    end
    idle_step();
    chk("lit_done_t9", 32'(s_done), 32'd1);
    chk("lit_stall_t9", 32'(s_stall), 32'd1);
    step(1'b0, 1'b1, 5'd12, 4'd9, 1'b0, 5'd0, 4'd0);
    chk("lit_stall_t10", 32'(s_stall), 32'd0);
    chk("lit_resume_t10", 32'(s_rd), 32'd1);

    // second complete flush (stall cycles accumulate to 20)
    step(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    for (int i = 0; i < 9; i++) idle_step();
    idle_step();
`ifdef RAT_FLUSH_PERF_EN
    chk("lit_perf_flush", perf_flush_cnt, 32'd2);
    chk("lit_perf_stall", perf_stall_cycles, 32'd20);
`endif

    // restart at T+4
    pulses = 0;
    step(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin idle_step(); pulses += int'(s_done); end
    step(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    pulses += int'(s_done);
    idle_step();
    chk("lit_restart_base", 32'(s_base), 32'd0);
    chk("lit_restart_en", 32'(s_clr), 32'd1);
    for (int i = 0; i < 8; i++) begin idle_step(); pulses += int'(s_done); end
    chk("lit_restart_done_t13", 32'(s_done), 32'd1);
    chk("lit_restart_pulses", 32'(pulses), 32'd1);
    idle_step();

    // flush during DONE
    step(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    for (int i = 0; i < 8; i++) idle_step();
    step(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    chk("lit_done_flush_nodone", 32'(s_done), 32'd0);
    chk("lit_done_flush_stall", 32'(s_stall), 32'd1);
    idle_step();
    chk("lit_rewalk_en", 32'(s_clr), 32'd1);
    chk("lit_rewalk_base", 32'(s_base), 32'd0);
    for (int i = 0; i < 9; i++) idle_step();

    // asynchronous reset mid-walk
    step(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    idle_step();
    idle_step();
    #3;
    rst_n = 1'b0;
    k = BIG; m_pf = 0; m_ps = 0;
    #1;
    chk("lit_arst_clr_en", 32'(rat_clr_en), 32'd0);
    chk("lit_arst_stall", 32'(dec_stall), 32'd0);
    chk("lit_arst_done", 32'(flush_done), 32'd0);
    idle_step();
    idle_step();
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 1'b1, 5'd17, 4'd11, 1'b1, 5'd3, 4'd2);
    chk("lit_arst_fwd_rd", 32'(s_rd), 32'd1);
    chk("lit_arst_fwd_cm", 32'(s_cm), 32'd1);
    chk("lit_arst_fwd_stall", 32'(s_stall), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 12; i++) idle_step();

    // final report
    chk("done_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
